frame_history_feeder: RTL and testbench
=======================================

# frame_history_feeder

Producer side of the temporal pixel bus consumed by the derivative calculators: accepts one raster pixel stream, stores the previous `NUM_DERIVATIVE_FRAMES-1` frames in on-chip banks, and emits every incoming pixel together with the co-located pixels of the older frames as one packed bus with an `en` strobe. It sits between the camera/pixel source and the x/y/t derivative stages, whose `en`/`pixels_in` inputs it drives directly.

## Interface
- `PIXEL_WIDTH`, 8, bits per pixel
- `NUM_DERIVATIVE_FRAMES`, 3, frames per output word (≥2)
- `IMAGE_WIDTH`, 64, pixels per line
- `IMAGE_HEIGHT`, 48, lines per frame; `FRAME_PIXELS = IMAGE_WIDTH*IMAGE_HEIGHT` (local)

- `clk`  in  1  sole clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  `pixel_in` valid this cycle
- `in_sof`  in  1  qualifies first pixel of a frame (ignored unless `in_valid`)
- `pixel_in`  in  `PIXEL_WIDTH`  raster-order pixel
- `en_out`  out  1  `pixels_out` valid this cycle
- `pixels_out`  out  `PIXEL_WIDTH*NUM_DERIVATIVE_FRAMES`  slice k at `[k*PIXEL_WIDTH +: PIXEL_WIDTH]`; slice 0 oldest frame, slice N-1 current pixel
- `frames_ready`  out  1  high while in RUN
- `frame_err`  out  1  one-cycle pulse on framing violation

## Operation
- States: IDLE, FILL, RUN. Reset → IDLE.
- IDLE: wait for `in_valid & in_sof`; that pixel starts frame 0 → FILL.
- Pixel counter `pix_cnt` (0..FRAME_PIXELS-1) is address into all banks; reset to 0 by every accepted `in_sof`, increments per accepted pixel.
- N-1 banks, `FRAME_PIXELS` deep. Write pointer `wr_bank` (0..N-2): accepted pixel written to `wr_bank` at `pix_cnt`; all banks read at same address, read-first (old data returned on the written bank).
- Frame completion (accepted pixel with `pix_cnt==FRAME_PIXELS-1`): `wr_bank` advances, wrapping N-2→0; `frames_stored` increments, saturating at N-1.
- FILL → RUN on accepted `in_sof` when `frames_stored==N-1`. FILL: writes occur, `en_out` stays 0.
- RUN: each accepted pixel produces one output word; slice k (k<N-1) = bank `(wr_bank+k) mod (N-1)`, slice N-1 = registered `pixel_in`.
- Short frame (accepted `in_sof` with `pix_cnt≠0` and frame incomplete): `frame_err` pulse; `frames_stored`←0, state→FILL; sof pixel starts a new frame at address 0, same cycle.
- Long frame (accepted pixel after completion, no `in_sof`): pixel dropped, no write, no `en_out`; `frame_err` pulses once per frame.
- `in_sof` at exactly `pix_cnt==0` after completion is normal.

## Timing
- Latency: pixel accepted at cycle t → `en_out`=1 with its word at t+1 (bank read is one registered stage; current pixel delayed one register to align).
- `en_out` is one cycle per accepted pixel; gaps in `in_valid` give gaps in `en_out`; `pixels_out` holds last value when `en_out`=0.
- `frames_ready` and `frame_err` registered; change at t+1 of causing pixel.
- Reset values: `en_out`=0, `pixels_out`=0, `frames_ready`=0, `frame_err`=0, `wr_bank`=0, `pix_cnt`=0, `frames_stored`=0. Bank contents not cleared.
- `rst` mid-frame: next cycle all of the above; any in-flight word dropped; stream restarts only at next `in_sof`.
- Back-to-back `in_valid` every cycle supported with no stalls.

## Structure
- Shared package: state enum (`IDLE`,`FILL`,`RUN`), `FRAME_PIXELS`, address-width function (`$clog2`), bank-rotate function `(wr_bank+k) mod (N-1)`.
- Sub-module `frame_bank_ram`: single-clock, one write port + one read port, read-first, registered read, depth/width parameters; N-1 instances via generate.

## Test plan
(N=3, PIXEL_WIDTH=8, IMAGE_WIDTH=2, IMAGE_HEIGHT=2.)
- Reset held 3 cycles with `in_valid` toggling → all outputs 0, no `en_out`.
- Frames A=0x10..0x13, B=0x20..0x23 then C=0x30..0x33, contiguous → no `en_out` during A/B; during C four `en_out` pulses, first `pixels_out`=0x302010, last 0x332313, each one cycle after input; `frames_ready` rises cycle after C's sof.
- Frame D=0x40..0x43 next → words 0x403020..0x433323 (bank wrap verified).
- D sent with `in_valid` low every other cycle → `en_out` pulses mirror gaps at +1 cycle, `pixels_out` stable between.
- Short frame: sof after 2 pixels of D → `frame_err` 1-cycle pulse, `frames_ready`=0, no `en_out` for next two full frames, output resumes on third.
- `rst` asserted mid-frame C → outputs 0 next cycle; restart requires two new frames before `en_out`.

Source files
------------

// File: rtl/frame_history_feeder_pkg.sv
// Shared types and helpers for the temporal pixel bus producer.
// Bank addressing and rotation are kept here so the top and the bank RAM agree on widths.
package frame_history_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } fhf_state_e;

    localparam int DEF_IMAGE_WIDTH  = 64;
    localparam int DEF_IMAGE_HEIGHT = 48;
    localparam int DEF_FRAME_PIXELS = DEF_IMAGE_WIDTH * DEF_IMAGE_HEIGHT;

    function automatic int frame_pixels(input int width, input int height);
        return width * height;
    endfunction

    // Never returns 0 so single-entry ranges still get a 1-bit index.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int bank_rotate(input int base, input int k, input int nbanks);
        return (nbanks > 0) ? ((base + k) % nbanks) : 0;
    endfunction

endpackage

// File: rtl/frame_history_feeder_bank_ram.sv
// One frame bank: single clock, one write and one read port, read-first, registered read.
// The read register only updates on rd_en so the output holds between reads.
module frame_bank_ram
    import frame_history_feeder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = DEF_FRAME_PIXELS,
    localparam int AW   = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_d;
    logic [WIDTH-1:0] rd_data_q;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/frame_history_feeder.sv
// Buffers the previous N-1 frames and emits each accepted pixel with its co-located history.
// state | meaning:  IDLE wait first sof | FILL storing history, no output | RUN emitting words
module frame_history_feeder
    import frame_history_feeder_pkg::*;
#(
    parameter int PIXEL_WIDTH           = 8,
    parameter int NUM_DERIVATIVE_FRAMES = 3,
    parameter int IMAGE_WIDTH           = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT          = DEF_IMAGE_HEIGHT
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         in_valid,
    input  logic                                         in_sof,
    input  logic [PIXEL_WIDTH-1:0]                       pixel_in,
    output logic                                         en_out,
    output logic [PIXEL_WIDTH*NUM_DERIVATIVE_FRAMES-1:0] pixels_out,
    output logic                                         frames_ready,
    output logic                                         frame_err
);

    localparam int N            = NUM_DERIVATIVE_FRAMES;
    localparam int NB           = N - 1;
    localparam int FRAME_PIXELS = frame_pixels(IMAGE_WIDTH, IMAGE_HEIGHT);
    localparam int AW           = addr_width(FRAME_PIXELS);
    localparam int BW           = addr_width(NB);
    localparam int SW           = addr_width(N);

    fhf_state_e state_q, state_d;
    logic [AW-1:0]          pix_cnt_q, pix_cnt_d;
    logic [BW-1:0]          wr_bank_q, wr_bank_d;
    logic [SW-1:0]          frames_stored_q, frames_stored_d;
    logic                   err_sent_q, err_sent_d;
    logic                   en_out_q, en_out_d;
    logic                   frames_ready_q, frames_ready_d;
    logic                   frame_err_q, frame_err_d;
    logic [PIXEL_WIDTH-1:0] pixel_dly_q, pixel_dly_d;
    logic [BW-1:0]          rot_base_q, rot_base_d;

    logic          wr_en;
    logic          rd_en;
    logic          emit;
    logic [AW-1:0] addr;

    logic [PIXEL_WIDTH-1:0] bank_rdata [NB];

    always_comb begin
        state_d         = state_q;
        pix_cnt_d       = pix_cnt_q;
        wr_bank_d       = wr_bank_q;
        frames_stored_d = frames_stored_q;
        err_sent_d      = err_sent_q;
        pixel_dly_d     = pixel_dly_q;
        rot_base_d      = rot_base_q;
        en_out_d        = 1'b0;
        frame_err_d     = 1'b0;
        wr_en           = 1'b0;
        emit            = 1'b0;
        addr            = pix_cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_sof) begin
                    state_d    = FILL;
                    addr       = '0;
                    wr_en      = 1'b1;
                    err_sent_d = 1'b0;
                end
            end
            default: begin
                // In FILL/RUN a zero counter means the previous frame completed.
                if (in_valid) begin
                    if (in_sof) begin
                        addr       = '0;
                        wr_en      = 1'b1;
                        err_sent_d = 1'b0;
                        if (pix_cnt_q != '0) begin
                            frame_err_d     = 1'b1;
                            frames_stored_d = '0;
                            state_d         = FILL;
                        end else if (state_q == RUN || frames_stored_q == SW'(NB)) begin
                            state_d = RUN;
                            emit    = 1'b1;
                        end
                    end else if (pix_cnt_q == '0) begin
                        if (!err_sent_q) begin
                            frame_err_d = 1'b1;
                            err_sent_d  = 1'b1;
                        end
                    end else begin
                        wr_en = 1'b1;
                        emit  = (state_q == RUN);
                    end
                end
            end
        endcase

        if (wr_en) begin
            if (addr == AW'(FRAME_PIXELS - 1)) begin
                pix_cnt_d = '0;
                wr_bank_d = (wr_bank_q == BW'(NB - 1)) ? '0 : wr_bank_q + BW'(1);
                if (frames_stored_q != SW'(NB)) begin
                    frames_stored_d = frames_stored_q + SW'(1);
                end
            end else begin
                pix_cnt_d = addr + AW'(1);
            end
        end

        if (emit) begin
            en_out_d    = 1'b1;
            pixel_dly_d = pixel_in;
            rot_base_d  = wr_bank_q;
        end

        rd_en          = emit;
        frames_ready_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            pix_cnt_q       <= '0;
            wr_bank_q       <= '0;
            frames_stored_q <= '0;
            err_sent_q      <= 1'b0;
            en_out_q        <= 1'b0;
            frames_ready_q  <= 1'b0;
            frame_err_q     <= 1'b0;
            pixel_dly_q     <= '0;
            rot_base_q      <= '0;
        end else begin
            state_q         <= state_d;
            pix_cnt_q       <= pix_cnt_d;
            wr_bank_q       <= wr_bank_d;
            frames_stored_q <= frames_stored_d;
            err_sent_q      <= err_sent_d;
            en_out_q        <= en_out_d;
            frames_ready_q  <= frames_ready_d;
            frame_err_q     <= frame_err_d;
            pixel_dly_q     <= pixel_dly_d;
            rot_base_q      <= rot_base_d;
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_bank
        frame_bank_ram #(
            .WIDTH (PIXEL_WIDTH),
            .DEPTH (FRAME_PIXELS)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_en && (wr_bank_q == BW'(b))),
            .wr_addr (addr),
            .wr_data (pixel_in),
            .rd_en   (rd_en),
            .rd_addr (addr),
            .rd_data (bank_rdata[b])
        );
    end

    // Slice 0 is the bank about to be overwritten, i.e. the oldest stored frame.
    for (genvar k = 0; k < NB; k++) begin : g_slice
        logic [BW-1:0] sel;
        assign sel = BW'(bank_rotate(int'(rot_base_q), k, NB));
        assign pixels_out[k*PIXEL_WIDTH +: PIXEL_WIDTH] = bank_rdata[sel];
    end

    assign pixels_out[NB*PIXEL_WIDTH +: PIXEL_WIDTH] = pixel_dly_q;
    assign en_out       = en_out_q;
    assign frames_ready = frames_ready_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_frame_history_feeder.sv
// Scoreboard bench: a frame-level model predicts words, frames_ready and frame_err per cycle;
// a negedge monitor compares them against the DUT independently of the stimulus process.
module tb_frame_history_feeder;

    localparam int PW = 8;
    localparam int N  = 3;
    localparam int IW = 2;
    localparam int IH = 2;
    localparam int FP = IW * IH;
    localparam int NB = N - 1;

    typedef logic [PW*N-1:0]  word_t;
    typedef logic [FP*PW-1:0] frame_t;
    typedef struct {
        word_t word;
        int    n;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic [PW-1:0] pixel_in = '0;
    logic          en_out;
    word_t         pixels_out;
    logic          frames_ready;
    logic          frame_err;

    int checks = 0;
    int errors = 0;
    int ncnt   = 0;

    exp_t  exp_q[$];
    word_t exp_out[int];
    bit    exp_ready[int];
    bit    exp_err[int];

    bit     m_running, m_run, m_done, m_err_sent;
    int     m_pos;
    frame_t m_cur;
    frame_t m_hist[$];
    word_t  m_last;

    frame_history_feeder #(
        .PIXEL_WIDTH           (PW),
        .NUM_DERIVATIVE_FRAMES (N),
        .IMAGE_WIDTH           (IW),
        .IMAGE_HEIGHT          (IH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_sof       (in_sof),
        .pixel_in     (pixel_in),
        .en_out       (en_out),
        .pixels_out   (pixels_out),
        .frames_ready (frames_ready),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ncnt <= ncnt + 1;

    // Store one pixel of the current frame; in run mode also predict its output word.
    task automatic m_store(input int n, input logic [PW-1:0] p);
        word_t w;
        m_cur[m_pos*PW +: PW] = p;
        if (m_run) begin
            w = '0;
            w[NB*PW +: PW] = p;
            for (int k = 0; k < NB; k++) w[k*PW +: PW] = m_hist[k][m_pos*PW +: PW];
            m_last = w;
            exp_q.push_back('{word: w, n: n});
        end
        if (m_pos == FP - 1) begin
            m_hist.push_back(m_cur);
            if (m_hist.size() > NB) void'(m_hist.pop_front());
            m_done = 1'b1;
            m_pos  = 0;
        end else begin
            m_pos++;
        end
    endtask

    task automatic model(input int n, input bit v, input bit s, input logic [PW-1:0] p, input bit r);
        bit err;
        err = 1'b0;
        if (r) begin
            m_running = 0; m_run = 0; m_done = 0; m_err_sent = 0; m_pos = 0;
            m_hist.delete();
            m_last = '0;
        end else if (v) begin
            if (!m_running) begin
                if (s) begin
                    m_running = 1; m_done = 0; m_err_sent = 0; m_pos = 0;
                    m_store(n, p);
                end
            end else if (s) begin
                if (!m_done) begin
                    err = 1'b1;
                    m_hist.delete();
                    m_run = 1'b0;
                end else if (m_hist.size() == NB) begin
                    m_run = 1'b1;
                end
                m_done = 0; m_err_sent = 0; m_pos = 0;
                m_store(n, p);
            end else if (m_done) begin
                if (!m_err_sent) begin
                    err = 1'b1;
                    m_err_sent = 1'b1;
                end
            end else begin
                m_store(n, p);
            end
        end
        exp_ready[n] = m_run;
        exp_err[n]   = err;
        exp_out[n]   = m_last;
    endtask

    task automatic drive(input bit v, input bit s, input logic [PW-1:0] p, input bit r);
        rst      = r;
        in_valid = v;
        in_sof   = s;
        pixel_in = p;
        model(ncnt + 1, v, s, p, r);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [PW-1:0] base, input bit gaps);
        for (int i = 0; i < FP; i++) begin
            if (gaps) drive(1'b0, 1'b0, PW'($urandom), 1'b0);
            drive(1'b1, i == 0, base + PW'(i), 1'b0);
        end
    endtask

    always @(negedge clk) begin
        int   n;
        exp_t e;
        n = ncnt;
        if (exp_ready.exists(n)) begin
            checks++;
            if (frames_ready !== exp_ready[n]) begin
                errors++;
                $display("FAIL frames_ready n=%0d got %b want %b", n, frames_ready, exp_ready[n]);
            end
            checks++;
            if (frame_err !== exp_err[n]) begin
                errors++;
                $display("FAIL frame_err n=%0d got %b want %b", n, frame_err, exp_err[n]);
            end
            if (en_out === 1'b0) begin
                checks++;
                if (pixels_out !== exp_out[n]) begin
                    errors++;
                    $display("FAIL pixels_hold n=%0d got %h want %h", n, pixels_out, exp_out[n]);
                end
            end
        end
        while (exp_q.size() > 0 && exp_q[0].n < n) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_en n=%0d got en_out=0 want word %h at n=%0d", n, e.word, e.n);
        end
        if (en_out !== 1'b0 && exp_ready.exists(n)) begin
            checks++;
            if (exp_q.size() == 0 || exp_q[0].n != n) begin
                errors++;
                $display("FAIL unexpected_en n=%0d got en_out=%b word %h want en_out=0", n, en_out, pixels_out);
            end else begin
                e = exp_q.pop_front();
                if (pixels_out !== e.word) begin
                    errors++;
                    $display("FAIL word n=%0d got %h want %h", n, pixels_out, e.word);
                end
            end
        end
    end

    initial begin
        int gpos;
        int rr;
        bit s;

        for (int i = 0; i < 3; i++) drive(i[0], 1'b1, PW'($urandom), 1'b1);

        send_frame(8'h10, 1'b0);
        send_frame(8'h20, 1'b0);
        send_frame(8'h30, 1'b0);
        send_frame(8'h40, 1'b0);
        send_frame(8'h50, 1'b1);

        // short frame, then two refill frames before output resumes
        drive(1'b1, 1'b1, 8'h60, 1'b0);
        drive(1'b1, 1'b0, 8'h61, 1'b0);
        send_frame(8'h70, 1'b0);
        send_frame(8'h80, 1'b0);
        send_frame(8'h90, 1'b1);

        // long frame: extra pixels dropped, single error pulse
        send_frame(8'hA0, 1'b0);
        drive(1'b1, 1'b0, 8'hAE, 1'b0);
        drive(1'b1, 1'b0, 8'hAF, 1'b0);
        send_frame(8'hB0, 1'b0);

        // reset mid-frame, stray pixels before the next sof are ignored
        drive(1'b1, 1'b1, 8'hC0, 1'b0);
        drive(1'b1, 1'b0, 8'hC1, 1'b0);
        drive(1'b1, 1'b0, 8'hC2, 1'b1);
        drive(1'b1, 1'b0, 8'h55, 1'b0);
        send_frame(8'hD0, 1'b0);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);

        gpos = 0;
        for (int i = 0; i < 500; i++) begin
            rr = $urandom_range(0, 99);
            if (rr < 1) begin
                drive(1'b0, 1'b0, '0, 1'b1);
                gpos = 0;
            end else if (rr < 25) begin
                drive(1'b0, 1'b0, PW'($urandom), 1'b0);
            end else begin
                s = (gpos == 0);
                if (rr < 29) s = !s;
                drive(1'b1, s, PW'($urandom), 1'b0);
                gpos = s ? 1 : (gpos + 1) % FP;
            end
        end

        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, '0, 1'b0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending words want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
